relu_max_pool: RTL and testbench

- Streaming ReLU plus 2x2, stride-2 max-pooling stage directly downstream of the single convolution engine.
- Consumes the convolution result stream (write strobe plus signed data, raster order) and emits pooled samples with a sequential output address for the next layer's memory.
- Needs no frame buffer; only one line of partial maxima is held.

---
 rtl/relu_max_pool_pkg.sv | 26 ++
 rtl/relu_max_pool_line_buffer.sv | 35 +++
 rtl/relu_max_pool.sv | 155 +++++++++++++++
 tb/tb_relu_max_pool.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/relu_max_pool_pkg.sv
// Shared types and helpers for the ReLU + 2x2 max-pool stage.
package relu_max_pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } poolState_t;

    // Pooled map dimension: the odd trailing row/column of the conv map is dropped.
    function automatic int poolSize(input int convSize);
        return convSize / 2;
    endfunction

    function automatic logic signed [31:0] signedMax(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        logic signed [31:0] m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/relu_max_pool_line_buffer.sv
// One line of partial 2x2 maxima: synchronous write, combinational read.
module pool_line_buffer
    import relu_max_pool_pkg::*;
#(
    parameter int dataWidth = 9,
    parameter int depth     = 6,
    parameter int addrWidth = 3
) (
    input  logic                        clk,
    input  logic                        writeEnable,
    input  logic [addrWidth-1:0]        address,
    input  logic signed [dataWidth-1:0] writeData,
    output logic signed [dataWidth-1:0] readData
);

    logic signed [dataWidth-1:0] lineBuf_r [depth];

    // Store the top-row pair maximum for the column pair at address.
    always_ff @(posedge clk) begin
        if (writeEnable && (int'(address) < depth)) begin
            lineBuf_r[address] <= writeData;
        end
    end

    // Addresses past the last pair only occur on dropped columns; return zero there.
    always_comb begin
        readData = {dataWidth{1'b0}};
        if (int'(address) < depth) begin
            readData = lineBuf_r[address];
        end else begin
            readData = {dataWidth{1'b0}};
        end
    end

endmodule

// File: rtl/relu_max_pool.sv
// Streaming ReLU followed by 2x2 stride-2 max pooling on a raster-order conv stream.
module relu_max_pool
    import relu_max_pool_pkg::*;
#(
    parameter int convRow      = 13,
    parameter int convColumn   = 12,
    parameter int dataWidth    = 9,
    parameter int addressWidth = 16,
    parameter bit reluEnable   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startPool,
    input  logic                        in_valid,
    input  logic signed [dataWidth-1:0] in_data,
    output logic                        out_valid,
    output logic signed [dataWidth-1:0] out_data,
    output logic [addressWidth-1:0]     out_address,
    output logic                        frameDone,
    output logic                        busy
);

    localparam int poolRow    = poolSize(convRow);
    localparam int poolColumn = poolSize(convColumn);
    localparam int colWidth   = $clog2(convColumn);
    localparam int rowWidth   = $clog2(convRow);

    poolState_t                  state_r, stateNext_s;
    logic [colWidth-1:0]         col_r;
    logic [rowWidth-1:0]         row_r;
    logic signed [dataWidth-1:0] pairMax_r, outData_r;
    logic [addressWidth-1:0]     outAddress_r;
    logic                        outValid_r, frameDone_r, busy_r;

    logic                        restart_s, accept_s, lastCol_s, lastRow_s, lastSample_s;
    logic                        colInPool_s, rowInPool_s, lineWrite_s;
    logic                        doneNext_s, busyNext_s;
    logic signed [dataWidth-1:0] reluData_s, pairNew_s, windowMax_s, lineRead_s;

    assign restart_s    = startPool && ((state_r == IDLE) || (state_r == RUN));
    assign accept_s     = (state_r == RUN) && in_valid && !startPool;
    assign lastCol_s    = (col_r == colWidth'(convColumn - 1));
    assign lastRow_s    = (row_r == rowWidth'(convRow - 1));
    assign lastSample_s = accept_s && lastCol_s && lastRow_s;
    assign colInPool_s  = (int'(col_r) < 2 * poolColumn);
    assign rowInPool_s  = (int'(row_r) < 2 * poolRow);
    assign lineWrite_s  = accept_s && colInPool_s && col_r[0] && !row_r[0];

    // ReLU and the running pair/window maxima.
    always_comb begin
        if (reluEnable && in_data[dataWidth-1]) begin
            reluData_s = {dataWidth{1'b0}};
        end else begin
            reluData_s = in_data;
        end
        pairNew_s   = dataWidth'(signedMax(32'(pairMax_r), 32'(reluData_s)));
        windowMax_s = dataWidth'(signedMax(32'(pairNew_s), 32'(lineRead_s)));
    end

    pool_line_buffer #(
        .dataWidth(dataWidth),
        .depth    (poolColumn),
        .addrWidth(colWidth - 1)
    ) lineBuffer (
        .clk        (clk),
        .writeEnable(lineWrite_s),
        .address    (col_r[colWidth-1:1]),
        .writeData  (pairNew_s),
        .readData   (lineRead_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic; startPool in RUN restarts rather than finishing.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE:    if (startPool) stateNext_s = RUN; else stateNext_s = IDLE;
            RUN:     if (startPool) stateNext_s = RUN;
                     else if (lastSample_s) stateNext_s = DONE;
                     else stateNext_s = RUN;
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        doneNext_s = 1'b0;
        busyNext_s = 1'b0;
        case (stateNext_s)
            RUN:     busyNext_s = 1'b1;
            DONE:    doneNext_s = (state_r == RUN);
            default: busyNext_s = 1'b0;
        endcase
    end

    // Raster position counters.
    always_ff @(posedge clk) begin
        if (reset || restart_s) begin
            col_r <= {colWidth{1'b0}};
            row_r <= {rowWidth{1'b0}};
        end else if (accept_s) begin
            if (lastCol_s) begin
                col_r <= {colWidth{1'b0}};
                row_r <= lastRow_s ? {rowWidth{1'b0}} : row_r + rowWidth'(1'b1);
            end else begin
                col_r <= col_r + colWidth'(1'b1);
            end
        end
    end

    // Pooling datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pairMax_r    <= {dataWidth{1'b0}};
            outData_r    <= {dataWidth{1'b0}};
            outValid_r   <= 1'b0;
            outAddress_r <= {addressWidth{1'b0}};
            frameDone_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            outValid_r  <= 1'b0;
            frameDone_r <= doneNext_s;
            busy_r      <= busyNext_s;
            if (restart_s) begin
                outAddress_r <= {addressWidth{1'b0}};
            end else if (outValid_r) begin
                outAddress_r <= outAddress_r + addressWidth'(1'b1);
            end
            if (accept_s && colInPool_s) begin
                if (!col_r[0]) begin
                    pairMax_r <= reluData_s;
                end else if (row_r[0] && rowInPool_s) begin
                    outData_r  <= windowMax_s;
                    outValid_r <= 1'b1;
                end
            end
        end
    end

    assign out_valid   = outValid_r;
    assign out_data    = outData_r;
    assign out_address = outAddress_r;
    assign frameDone   = frameDone_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_relu_max_pool.sv
// Directed bench: two instances (ReLU on / off) share one stimulus stream.
module tb_relu_max_pool;

    logic clk = 1'b0;
    logic reset, startPool, in_valid;
    logic signed [8:0] in_data;
    logic aValid, aDone, aBusy, bValid, bDone, bBusy;
    logic signed [8:0] aData, bData;
    logic [15:0] aAddr, bAddr;

    int total = 0;
    int bad   = 0;
    logic signed [8:0] frm [13][12];

    // Expected outputs after the next active edge; mState 0=IDLE 1=RUN 2=DONE.
    int mState = 0;
    bit pendV = 1'b0, pendDone = 1'b0, pendBusy = 1'b0, pendReset = 1'b1;
    int pendA = 0, pendDA = 0, pendDB = 0;

    always #5 clk = ~clk;

    relu_max_pool #(.convRow(13), .convColumn(12), .dataWidth(9), .addressWidth(16),
                    .reluEnable(1'b1)) dutA (
        .clk(clk), .reset(reset), .startPool(startPool), .in_valid(in_valid),
        .in_data(in_data), .out_valid(aValid), .out_data(aData),
        .out_address(aAddr), .frameDone(aDone), .busy(aBusy));

    relu_max_pool #(.convRow(13), .convColumn(12), .dataWidth(9), .addressWidth(16),
                    .reluEnable(1'b0)) dutB (
        .clk(clk), .reset(reset), .startPool(startPool), .in_valid(in_valid),
        .in_data(in_data), .out_valid(bValid), .out_data(bData),
        .out_address(bAddr), .frameDone(bDone), .busy(bBusy));

    task automatic checkEq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int reluOf(input int x, input bit en);
        return (en && x < 0) ? 0 : x;
    endfunction

    function automatic int winMax(input int r, input int c, input bit en);
        int m;
        m = reluOf(frm[r-1][c-1], en);
        if (reluOf(frm[r-1][c], en) > m) m = reluOf(frm[r-1][c], en);
        if (reluOf(frm[r][c-1], en) > m) m = reluOf(frm[r][c-1], en);
        if (reluOf(frm[r][c], en) > m) m = reluOf(frm[r][c], en);
        return m;
    endfunction

    task automatic checkOuts();
        checkEq("validA", int'(aValid), int'(pendV));
        checkEq("validB", int'(bValid), int'(pendV));
        checkEq("doneA", int'(aDone), int'(pendDone));
        checkEq("doneB", int'(bDone), int'(pendDone));
        checkEq("busyA", int'(aBusy), int'(pendBusy));
        checkEq("busyB", int'(bBusy), int'(pendBusy));
        if (pendV) begin
            checkEq("dataA", int'(aData), pendDA);
            checkEq("dataB", int'(bData), pendDB);
            checkEq("addrA", int'(aAddr), pendA);
            checkEq("addrB", int'(bAddr), pendA);
        end
        if (pendReset) begin
            checkEq("rstDataA", int'(aData), 0);
            checkEq("rstAddrA", int'(aAddr), 0);
            checkEq("rstDataB", int'(bData), 0);
            checkEq("rstAddrB", int'(bAddr), 0);
        end
    endtask

    task automatic resetCycle();
        @(negedge clk);
        checkOuts();
        reset = 1'b1; startPool = 1'b0; in_valid = 1'b0; in_data = 9'sd0;
        mState = 0; pendV = 1'b0; pendDone = 1'b0; pendBusy = 1'b0; pendReset = 1'b1;
    endtask

    // Check the previous edge's outputs, then drive one cycle of inputs.
    task automatic cycle(input bit sp, input bit v, input int d, input int r, input int c);
        @(negedge clk);
        checkOuts();
        reset = 1'b0; startPool = sp; in_valid = v; in_data = 9'(d);
        pendV = 1'b0; pendDone = 1'b0; pendReset = 1'b0;
        if (mState == 2) begin
            mState = 0;
        end else if (sp) begin
            mState = 1;
        end else if (mState == 1 && v) begin
            if ((r % 2 == 1) && (c % 2 == 1) && r < 12 && c < 12) begin
                pendV  = 1'b1;
                pendA  = (r / 2) * 6 + c / 2;
                pendDA = winMax(r, c, 1'b1);
                pendDB = winMax(r, c, 1'b0);
            end
            if (r == 12 && c == 11) begin
                mState   = 2;
                pendDone = 1'b1;
            end
        end
        pendBusy = (mState == 1);
    endtask

    task automatic sendSamples(input int maxGap, input int count);
        for (int idx = 0; idx < count; idx++) begin
            int g;
            g = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            repeat (g) cycle(1'b0, 1'b0, 0, 0, 0);
            cycle(1'b0, 1'b1, int'(frm[idx / 12][idx % 12]), idx / 12, idx % 12);
        end
    endtask

    task automatic runFrame(input int maxGap);
        cycle(1'b1, 1'b0, 0, 0, 0);
        sendSamples(maxGap, 156);
        cycle(1'b1, 1'b0, 0, 0, 0);     // startPool during DONE is ignored
        repeat (2) cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic fillFrame(input int kind);
        for (int r = 0; r < 13; r++) begin
            for (int c = 0; c < 12; c++) begin
                case (kind)
                    0:       frm[r][c] = 9'(r * 12 + c);
                    1:       frm[r][c] = -9'sd5;
                    default: frm[r][c] = 9'sd0;
                endcase
            end
        end
    endtask

    initial begin
        reset = 1'b1; startPool = 1'b0; in_valid = 1'b0; in_data = 9'sd0;
        resetCycle();
        cycle(1'b0, 1'b0, 0, 0, 0);

        fillFrame(0);
        runFrame(0);

        fillFrame(1);
        runFrame(0);

        fillFrame(2);
        frm[1][1] = 9'sd100;
        runFrame(0);

        fillFrame(2);
        frm[0][0] = -9'sd256;
        runFrame(0);

        fillFrame(0);
        runFrame(5);

        // Restart after 30 samples discards the partial frame.
        cycle(1'b1, 1'b0, 0, 0, 0);
        sendSamples(0, 30);
        runFrame(0);

        // Reset mid-frame, then stray samples in IDLE, then a clean frame.
        frm[5][3] = -9'sd77;
        cycle(1'b1, 1'b0, 0, 0, 0);
        sendSamples(1, 40);
        resetCycle();
        resetCycle();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 50, 1, 1);
        runFrame(2);

        cycle(1'b0, 1'b0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
